sd_rxframer: RTL and testbench
==============================

// Module: sd_rxframer
//
// PURPOSE
// Host-side SD data-receive framer, directly downstream of the card's data
// transmitter on sd_dat. Samples DAT lines on strobes from the clock
// generator, finds the start bit, packs payload into 32-bit words, checks
// per-line CRC16 and end bit, and reports done/error/timeout to the command
// FSM. The mdl_sdio card model drives its inputs in bench.
//
// PARAMETERS
// LGLEN      9   log2 of max block length in bytes (512)
// LGTIMEOUT  23  width of start-bit timeout counter (in sample strobes)
//
// PORTS
// i_clk        in   1            system clock
// i_reset_n    in   1            asynchronous, active-low reset
// i_en         in   1            arm receiver; low aborts any frame
// i_cfg_width  in   1            0: 1-bit bus (DAT0 only), 1: 4-bit bus
// i_len        in   LGLEN+1      block length, bytes; [1:0] ignored
// i_timeout    in   LGTIMEOUT    start-bit wait limit, in strobes
// i_pedge      in   1            one-cycle strobe: sample i_dat this cycle
// i_dat        in   4            sampled sd_dat[3:0]
// o_valid      out  1            one-cycle pulse, o_data holds a word
// o_data       out  32           payload word, first bit received in [31]
// o_last       out  1            with o_valid: final word of block
// o_busy       out  1            state != IDLE
// o_done       out  1            one-cycle pulse: frame finished or timed out
// o_err        out  1            valid with o_done: crc|end-bit|timeout
// o_crc_err    out  1            valid with o_done: any line CRC mismatch
// o_timeout    out  1            valid with o_done: no start bit in time
//
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; CRCs, counters, shift reg cleared.
// Active lines: width 0 -> DAT0; width 1 -> DAT[3:0]. Width/len latched
//   at arm; changes mid-frame ignored.
// All state advances only on cycles with i_pedge=1 (except arm/abort/done).
// IDLE: i_en=1 -> WAIT_START; load tmo <= i_timeout, nwords <= i_len>>2.
// WAIT_START (per strobe): all active lines 0 -> start bit -> DATA
//   (nwords=0 -> CRC). Else tmo==0 -> DONE with timeout, else tmo-=1.
//   i_timeout=0: times out on first strobe lacking a start bit.
// DATA: shift in 1 bit (1b) or nibble, DAT3 MSB (4b); word complete after
//   32 or 8 strobes. o_valid/o_data (+o_last on final word) asserted the
//   cycle after the completing strobe; no backpressure, sink must accept.
//   After final word -> CRC.
// CRC16 per active line: x^16+x^12+x^5+1, init 0, over data bits only,
//   MSB first. CRC: 16 strobes compare received bits to each line's CRC;
//   any mismatch sets crc_err. Then -> STOP.
// STOP: one strobe; any active line 0 -> end-bit error. -> DONE.
// DONE: o_done pulses 1 cycle (cycle after stop strobe, or after timeout
//   strobe) with flags; o_err = crc_err|end_err|timeout. Stays in DONE
//   (o_busy=1) until i_en=0, then IDLE. No rearm without i_en falling.
// Abort: i_en=0 in any state -> IDLE next cycle; no o_done, no o_valid.
// Inactive lines (DAT[3:1] in 1b mode) never checked.
// Async reset mid-frame: immediate IDLE, outputs 0, partial word dropped.
//
// TESTING
// 1b, len=512, start on strobe 3, data = incrementing bytes 00..FF,00..FF,
//   correct CRC -> 128 o_valid, first 32'h00010203, o_last on 128th,
//   o_done with o_err=0.
// 4b, len=8, words 32'hDEADBEEF,32'h01234567, correct CRCs -> 2 o_valid,
//   each 8 strobes apart; o_done 17 strobes after last word, o_err=0.
// 4b, len=8, DAT2 CRC bit 5 flipped -> data words delivered, o_done with
//   o_crc_err=1, o_err=1, o_timeout=0.
// i_timeout=10, DAT held 4'hF -> o_done on 11th strobe with o_timeout=1,
//   no o_valid.
// 1b, len=4, end bit driven 0 -> o_done, o_err=1, o_crc_err=0.
// i_en dropped after 40 data strobes of len=512 -> IDLE next cycle, no
//   o_done; rearm succeeds on clean frame.

Source files
------------

// File: rtl/sd_rxframer_if.sv
// Bundle between the SD data-receive framer and its surroundings.
// The framer takes the slave side; the command FSM / bench take the master side.
interface sd_rxframer_if #(
    parameter int LGLEN     = 9,
    parameter int LGTIMEOUT = 23
);
    logic                 i_en;
    logic                 i_cfg_width;
    logic [LGLEN:0]       i_len;
    logic [LGTIMEOUT-1:0] i_timeout;
    logic                 i_pedge;
    logic [3:0]           i_dat;

    logic                 o_valid;
    logic [31:0]          o_data;
    logic                 o_last;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;
    logic                 o_crc_err;
    logic                 o_timeout;

    modport slave (
        input  i_en, i_cfg_width, i_len, i_timeout, i_pedge, i_dat,
        output o_valid, o_data, o_last, o_busy, o_done, o_err, o_crc_err, o_timeout
    );

    modport master (
        output i_en, i_cfg_width, i_len, i_timeout, i_pedge, i_dat,
        input  o_valid, o_data, o_last, o_busy, o_done, o_err, o_crc_err, o_timeout
    );
endinterface

// File: rtl/sd_rxframer.sv
// Host-side SD data-block receiver: start-bit hunt, word packing, per-line
// CRC16 and end-bit check, with a single done/error report per frame.
module sd_rxframer #(
    parameter int LGLEN     = 9,
    parameter int LGTIMEOUT = 23
) (
    input logic          i_clk,
    input logic          i_reset_n,
    sd_rxframer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        STOP,
        DONE
    } state_t;

    localparam logic [LGLEN-2:0] ONE_WORD = 1;

    state_t               state;
    state_t               state_nxt;
    logic [LGTIMEOUT-1:0] tmo;
    logic [LGLEN-2:0]     nwords;
    logic                 wide;
    logic [4:0]           bit_cnt;
    logic [3:0]           crc_cnt;
    logic [31:0]          sreg;
    logic [15:0]          crc [4];
    logic                 crc_err;
    logic                 end_err;
    logic                 tmo_flag;
    logic                 valid_q;
    logic                 last_q;
    logic [31:0]          data_q;
    logic                 done_q;

    logic [3:0]           act_mask;
    logic                 start_seen;
    logic                 end_bad;
    logic                 word_end;
    logic [31:0]          shifted;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Line-mask helpers; bus width is the value latched when the frame was armed.
    always_comb begin
        act_mask   = wide ? 4'hF : 4'h1;
        start_seen = ((bus.i_dat & act_mask) == 4'h0);
        end_bad    = ((bus.i_dat & act_mask) != act_mask);
        word_end   = (bit_cnt == (wide ? 5'd7 : 5'd31));
        shifted    = wide ? {sreg[27:0], bus.i_dat} : {sreg[30:0], bus.i_dat[0]};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line-state transitions only move on strobes; arming and abort do not wait for one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_en) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (bus.i_pedge) begin
                    if (start_seen)     state_nxt = (nwords == '0) ? CRC : DATA;
                    else if (tmo == '0) state_nxt = DONE;
                end
            end
            DATA: begin
                if (bus.i_pedge && word_end && (nwords == ONE_WORD)) state_nxt = CRC;
            end
            CRC: begin
                if (bus.i_pedge && (crc_cnt == 4'd15)) state_nxt = STOP;
            end
            STOP: begin
                if (bus.i_pedge) state_nxt = DONE;
            end
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (!bus.i_en) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo      <= '0;
            nwords   <= '0;
            wide     <= 1'b0;
            bit_cnt  <= '0;
            crc_cnt  <= '0;
            sreg     <= '0;
            for (int l = 0; l < 4; l++) crc[l] <= '0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            tmo_flag <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= (state != DONE) && (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.i_en) begin
                        tmo      <= bus.i_timeout;
                        nwords   <= bus.i_len[LGLEN:2];
                        wide     <= bus.i_cfg_width;
                        bit_cnt  <= '0;
                        crc_cnt  <= '0;
                        sreg     <= '0;
                        for (int l = 0; l < 4; l++) crc[l] <= '0;
                        crc_err  <= 1'b0;
                        end_err  <= 1'b0;
                        tmo_flag <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (bus.i_pedge && !start_seen) begin
                        if (tmo == '0) tmo_flag <= 1'b1;
                        else           tmo      <= tmo - 1'b1;
                    end
                end
                DATA: begin
                    if (bus.i_pedge) begin
                        sreg <= shifted;
                        for (int l = 0; l < 4; l++) crc[l] <= crc_step(crc[l], bus.i_dat[l]);
                        if (word_end) begin
                            bit_cnt <= '0;
                            nwords  <= nwords - 1'b1;
                            data_q  <= shifted;
                            valid_q <= bus.i_en;
                            last_q  <= bus.i_en && (nwords == ONE_WORD);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                CRC: begin
                    if (bus.i_pedge) begin
                        for (int l = 0; l < 4; l++) begin
                            if (act_mask[l] && (bus.i_dat[l] != crc[l][15])) crc_err <= 1'b1;
                            crc[l] <= {crc[l][14:0], 1'b0};
                        end
                        crc_cnt <= crc_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (bus.i_pedge && end_bad) end_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_data    = data_q;
    assign bus.o_last    = last_q;
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_done    = done_q;
    assign bus.o_err     = crc_err | end_err | tmo_flag;
    assign bus.o_crc_err = crc_err;
    assign bus.o_timeout = tmo_flag;

endmodule

// File: tb/tb_sd_rxframer.sv
// Scoreboard bench for sd_rxframer: frames are built and CRC'd in the bench,
// expected words are queued as driven and popped by the output monitor.
module tb_sd_rxframer;

    localparam int LGLEN     = 9;
    localparam int LGTIMEOUT = 23;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    sd_rxframer_if #(.LGLEN(LGLEN), .LGTIMEOUT(LGTIMEOUT)) bus ();

    sd_rxframer #(.LGLEN(LGLEN), .LGTIMEOUT(LGTIMEOUT)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] frame_words[$];
    int          valid_strobes[$];
    int          valid_cnt;
    int          done_cnt;
    int          done_strobe;
    int          strobe_n;
    logic [31:0] first_word;
    logic        d_err, d_crc, d_tmo;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    // Output monitor: pops the scoreboard on every word and snapshots done flags.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_word got=%h expected none", bus.o_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_data !== e.data || bus.o_last !== e.last) begin
                    fails++;
                    $display("[TB] FAIL word got=%h last=%b expected=%h last=%b",
                             bus.o_data, bus.o_last, e.data, e.last);
                end
            end
            if (valid_cnt == 0) first_word = bus.o_data;
            valid_cnt++;
            valid_strobes.push_back(strobe_n);
        end
        if (bus.o_done) begin
            done_cnt++;
            done_strobe = strobe_n;
            d_err = bus.o_err;
            d_crc = bus.o_crc_err;
            d_tmo = bus.o_timeout;
        end
    end

    task automatic clear_counts();
        exp_q.delete();
        valid_strobes.delete();
        valid_cnt   = 0;
        done_cnt    = 0;
        done_strobe = -1;
        strobe_n    = 0;
        first_word  = '0;
        d_err = 1'bx; d_crc = 1'bx; d_tmo = 1'bx;
    endtask

    task automatic strobe(input logic [3:0] d);
        bus.i_dat   = d;
        bus.i_pedge = 1'b1;
        @(posedge clk); #1;
        bus.i_pedge = 1'b0;
        strobe_n++;
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && done_cnt == 0; i++) @(posedge clk);
        #1;
    endtask

    task automatic drop_en();
        bus.i_en = 1'b0;
        @(posedge clk); #1;
    endtask

    // stop_mode 1 drops i_en, 2 asserts reset, after stop_after data strobes.
    task automatic send_frame(input logic w4, input int nbytes, input int pre,
                              input int flip_line, input int flip_bit, input logic end_val,
                              input int stop_after, input int stop_mode);
        logic [15:0] c [4];
        logic [31:0] cur;
        logic [3:0]  d;
        int nw, per, k;
        nw  = nbytes / 4;
        per = w4 ? 8 : 32;
        k   = 0;
        for (int l = 0; l < 4; l++) c[l] = '0;
        bus.i_cfg_width = w4;
        bus.i_len       = 10'(nbytes);
        bus.i_en        = 1'b1;
        @(posedge clk); #1;
        bus.i_cfg_width = ~w4;
        bus.i_len       = 10'd4;
        for (int i = 0; i < pre - 1; i++) strobe(4'hF);
        strobe(w4 ? 4'h0 : 4'hE);
        for (int w = 0; w < nw; w++) begin
            cur = frame_words[w];
            for (int s = 0; s < per; s++) begin
                if (w4) d = cur[31 - 4*s -: 4];
                else begin
                    d    = 4'($urandom);
                    d[0] = cur[31 - s];
                end
                for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], d[l]);
                if (s == per - 1) exp_q.push_back('{cur, (w == nw - 1)});
                strobe(d);
                k++;
                if (k == stop_after) begin
                    if (stop_mode == 1) bus.i_en = 1'b0;
                    else rst_n = 1'b0;
                    return;
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            d = 4'($urandom);
            for (int l = 0; l < (w4 ? 4 : 1); l++) begin
                d[l] = c[l][15 - i];
                if (l == flip_line && (15 - i) == flip_bit) d[l] = ~d[l];
            end
            strobe(d);
        end
        d = w4 ? {4{end_val}} : {3'($urandom), end_val};
        strobe(d);
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.i_en        = 1'b0;
        bus.i_cfg_width = 1'b0;
        bus.i_len       = '0;
        bus.i_timeout   = 23'd100000;
        bus.i_pedge     = 1'b0;
        bus.i_dat       = 4'hF;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_busy got=%b expected=0", bus.o_busy);
        end
        tests++;
        if ({bus.o_valid, bus.o_last, bus.o_done, bus.o_data} !== 35'd0) begin
            fails++; $display("[TB] FAIL reset_out got=%b%b%b %h expected all 0",
                              bus.o_valid, bus.o_last, bus.o_done, bus.o_data);
        end
        tests++;
        if ({bus.o_err, bus.o_crc_err, bus.o_timeout} !== 3'b000) begin
            fails++; $display("[TB] FAIL reset_flags got=%b%b%b expected=000",
                              bus.o_err, bus.o_crc_err, bus.o_timeout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_1b_full();
        logic [7:0] b;
        clear_counts();
        frame_words.delete();
        for (int j = 0; j < 128; j++) begin
            b = 8'(4*j);
            frame_words.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
        send_frame(1'b0, 512, 3, -1, 0, 1'b1, -1, 0);
        wait_done();
        tests++;
        if (valid_cnt !== 128 || exp_q.size() !== 0) begin
            fails++; $display("[TB] FAIL 1b_count got=%0d left=%0d expected=128 left=0", valid_cnt, exp_q.size());
        end
        tests++;
        if (first_word !== 32'h00010203) begin
            fails++; $display("[TB] FAIL 1b_first got=%h expected=00010203", first_word);
        end
        tests++;
        if (done_cnt !== 1 || done_strobe !== 4116) begin
            fails++; $display("[TB] FAIL 1b_done got=%0d@%0d expected=1@4116", done_cnt, done_strobe);
        end
        tests++;
        if ({d_err, d_crc, d_tmo} !== 3'b000) begin
            fails++; $display("[TB] FAIL 1b_flags got=%b%b%b expected=000", d_err, d_crc, d_tmo);
        end
        strobe(4'h0);
        strobe(4'hF);
        tests++;
        if (bus.o_busy !== 1'b1 || done_cnt !== 1) begin
            fails++; $display("[TB] FAIL hold_done busy=%b dones=%0d expected busy=1 dones=1", bus.o_busy, done_cnt);
        end
        drop_en();
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("[TB] FAIL release_busy got=%b expected=0", bus.o_busy);
        end
    endtask

    task automatic test_4b_short();
        clear_counts();
        frame_words = '{32'hDEADBEEF, 32'h01234567};
        send_frame(1'b1, 8, 1, -1, 0, 1'b1, -1, 0);
        wait_done();
        tests++;
        if (valid_strobes.size() !== 2 || (valid_strobes[1] - valid_strobes[0]) !== 8) begin
            fails++; $display("[TB] FAIL 4b_spacing got=%0d words gap=%0d expected=2 words gap=8",
                              valid_strobes.size(), (valid_strobes.size() == 2) ? valid_strobes[1] - valid_strobes[0] : -1);
        end
        tests++;
        if (done_cnt !== 1 || valid_strobes.size() !== 2 || (done_strobe - valid_strobes[1]) !== 17) begin
            fails++; $display("[TB] FAIL 4b_done_delay got=%0d dones, done@%0d expected 1 done 17 after last word",
                              done_cnt, done_strobe);
        end
        tests++;
        if ({d_err, d_crc, d_tmo} !== 3'b000) begin
            fails++; $display("[TB] FAIL 4b_flags got=%b%b%b expected=000", d_err, d_crc, d_tmo);
        end
        drop_en();
    endtask

    task automatic test_crc_err();
        clear_counts();
        frame_words = '{32'hDEADBEEF, 32'h01234567};
        send_frame(1'b1, 8, 2, 2, 5, 1'b1, -1, 0);
        wait_done();
        tests++;
        if (valid_cnt !== 2 || done_cnt !== 1) begin
            fails++; $display("[TB] FAIL crc_words got=%0d words %0d dones expected=2 words 1 done", valid_cnt, done_cnt);
        end
        tests++;
        if ({d_err, d_crc, d_tmo} !== 3'b110) begin
            fails++; $display("[TB] FAIL crc_flags got=%b%b%b expected=110", d_err, d_crc, d_tmo);
        end
        drop_en();
    endtask

    task automatic test_timeout();
        clear_counts();
        bus.i_timeout   = 23'd10;
        bus.i_cfg_width = 1'b1;
        bus.i_len       = 10'd8;
        bus.i_en        = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) strobe(4'hF);
        tests++;
        if (done_cnt !== 0) begin
            fails++; $display("[TB] FAIL tmo_early got=%0d dones after 10 strobes expected=0", done_cnt);
        end
        strobe(4'hF);
        wait_done();
        tests++;
        if (done_cnt !== 1 || done_strobe !== 11 || valid_cnt !== 0) begin
            fails++; $display("[TB] FAIL tmo_done got=%0d@%0d words=%0d expected=1@11 words=0",
                              done_cnt, done_strobe, valid_cnt);
        end
        tests++;
        if ({d_err, d_crc, d_tmo} !== 3'b101) begin
            fails++; $display("[TB] FAIL tmo_flags got=%b%b%b expected=101", d_err, d_crc, d_tmo);
        end
        bus.i_timeout = 23'd100000;
        drop_en();
    endtask

    task automatic test_end_err();
        clear_counts();
        frame_words = '{32'hA5C30F96};
        send_frame(1'b0, 4, 2, -1, 0, 1'b0, -1, 0);
        wait_done();
        tests++;
        if (done_cnt !== 1 || valid_cnt !== 1) begin
            fails++; $display("[TB] FAIL end_done got=%0d dones %0d words expected=1 1", done_cnt, valid_cnt);
        end
        tests++;
        if ({d_err, d_crc, d_tmo} !== 3'b100) begin
            fails++; $display("[TB] FAIL end_flags got=%b%b%b expected=100", d_err, d_crc, d_tmo);
        end
        drop_en();
    endtask

    task automatic test_abort_rearm();
        logic [7:0] b;
        clear_counts();
        frame_words.delete();
        for (int j = 0; j < 128; j++) begin
            b = 8'(4*j);
            frame_words.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
        end
        send_frame(1'b0, 512, 1, -1, 0, 1'b1, 40, 1);
        @(posedge clk); #1;
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++; $display("[TB] FAIL abort_busy got=%b expected=0", bus.o_busy);
        end
        for (int i = 0; i < 20; i++) strobe(4'(i));
        tests++;
        if (done_cnt !== 0 || valid_cnt !== 1 || exp_q.size() !== 0) begin
            fails++; $display("[TB] FAIL abort_quiet got=%0d dones %0d words expected=0 dones 1 word",
                              done_cnt, valid_cnt);
        end
        clear_counts();
        frame_words = '{32'h12345678};
        send_frame(1'b0, 4, 2, -1, 0, 1'b1, -1, 0);
        wait_done();
        tests++;
        if (done_cnt !== 1 || valid_cnt !== 1 || {d_err, d_crc, d_tmo} !== 3'b000) begin
            fails++; $display("[TB] FAIL rearm got=%0d dones %0d words flags=%b%b%b expected=1 1 000",
                              done_cnt, valid_cnt, d_err, d_crc, d_tmo);
        end
        drop_en();
    endtask

    task automatic test_async_reset();
        clear_counts();
        frame_words = '{32'hCAFEF00D, 32'h55AA33CC};
        send_frame(1'b1, 8, 1, -1, 0, 1'b1, 5, 2);
        #1;
        tests++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_data !== 32'd0) begin
            fails++; $display("[TB] FAIL async_reset busy=%b valid=%b data=%h expected 0 0 0",
                              bus.o_busy, bus.o_valid, bus.o_data);
        end
        bus.i_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (done_cnt !== 0 || valid_cnt !== 0) begin
            fails++; $display("[TB] FAIL async_quiet got=%0d dones %0d words expected=0 0", done_cnt, valid_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_1b_full();
        test_4b_short();
        test_crc_err();
        test_timeout();
        test_end_err();
        test_abort_rearm();
        test_async_reset();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
